geig_stack_framer: RTL

- Reader end of the geiger data stack interface. Snapshots the 80-bit G_DATA_STACK when geig_data_handling signals an update.
- Serializes the snapshot into a framed byte stream over a valid/ready handshake: sync byte, 10 data bytes, checksum.
- Sits between geig_data_handling and the downlink/UART byte transmitter, and replaces the bench-only stack harness in flight builds.

---
 rtl/geig_stack_framer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/geig_stack_framer.sv
// geig_stack_framer
//   Reader end of the geiger data stack. Snapshots G_DATA_STACK on each
//   STACK_UPDATE pulse and streams it out as a framed byte sequence over a
//   valid/ready handshake:
//     SYNC_BYTE, [STACK_BYTES when GEIG_FRAME_LEN_EN], data bytes (MSB first), checksum.
//   The checksum is the mod-256 sum of every byte after SYNC.
//   Updates that arrive mid-frame are parked in a one-deep pending buffer.
//   When a parked snapshot is replaced before it is sent, OVERRUN_CNT counts it,
//   saturating at 255.
//
// Build option:
//   GEIG_FRAME_LEN_EN  - when defined, a length byte follows SYNC.
//
// Ports:
//   CLK_1MHZ      in   system clock
//   RESET         in   asynchronous active-high reset
//   G_DATA_STACK  in   stack contents, valid while STACK_UPDATE is high
//   STACK_UPDATE  in   one-cycle pulse, new stack available
//   TX_READY      in   downstream accepts TX_DATA this cycle
//   TX_DATA       out  current frame byte
//   TX_VALID      out  TX_DATA is valid
//   FRAME_BUSY    out  framer is not idle
//   OVERRUN_CNT   out  snapshots discarded unsent (saturating)
module geig_stack_framer #(
  parameter int          STACK_BYTES = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                       CLK_1MHZ,
  input  logic                       RESET,
  input  logic [8*STACK_BYTES-1:0]   G_DATA_STACK,
  input  logic                       STACK_UPDATE,
  input  logic                       TX_READY,
  output logic [7:0]                 TX_DATA,
  output logic                       TX_VALID,
  output logic                       FRAME_BUSY,
  output logic [7:0]                 OVERRUN_CNT
);

  localparam int              SW       = 8 * STACK_BYTES;
  localparam int              IW       = $clog2(STACK_BYTES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(STACK_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
`ifdef GEIG_FRAME_LEN_EN
    ST_LEN  = 3'd2,
`endif
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  // Byte idx of a snapshot, byte 0 being the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [SW-1:0] buf_v,
                                          input logic [IW-1:0] idx);
    logic [SW-1:0] sh;
    sh = buf_v >> (8 * (STACK_BYTES - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'h01;
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [SW-1:0]   active_q, active_d;
  logic [SW-1:0]   pend_buf_q, pend_buf_d;
  logic            pend_q, pend_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      ovr_q, ovr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            xfer;

  // Next-state, buffer, checksum and registered-output computation.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pend_buf_d = pend_buf_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    ovr_d      = ovr_q;
    tx_data_d  = 8'h00;
    xfer       = tx_valid_q & TX_READY;

    if (state_q == ST_IDLE) begin
      if (STACK_UPDATE) begin
        // Fresh data wins; an unsent pending snapshot is dropped.
        active_d = G_DATA_STACK;
        state_d  = ST_SYNC;
        if (pend_q) begin
          pend_d = 1'b0;
          ovr_d  = sat_inc(ovr_q);
        end else begin
          pend_d = pend_q;
        end
      end else if (pend_q) begin
        active_d = pend_buf_q;
        pend_d   = 1'b0;
        state_d  = ST_SYNC;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      // Mid-frame updates are parked; the frame in flight is untouched.
      if (STACK_UPDATE) begin
        pend_buf_d = G_DATA_STACK;
        pend_d     = 1'b1;
        if (pend_q) begin
          ovr_d = sat_inc(ovr_q);
        end else begin
          ovr_d = ovr_q;
        end
      end else begin
        pend_d = pend_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        idx_d = idx_q;
      end
      ST_SYNC: begin
        if (xfer) begin
          csum_d  = 8'h00;
          idx_d   = '0;
`ifdef GEIG_FRAME_LEN_EN
          state_d = ST_LEN;
`else
          state_d = ST_DATA;
`endif
        end else begin
          state_d = ST_SYNC;
        end
      end
`ifdef GEIG_FRAME_LEN_EN
      ST_LEN: begin
        if (xfer) begin
          csum_d  = csum_q + 8'(STACK_BYTES);
          state_d = ST_DATA;
        end else begin
          state_d = ST_LEN;
        end
      end
`endif
      ST_DATA: begin
        if (xfer) begin
          csum_d = csum_q + byte_sel(active_q, idx_q);
          if (idx_q == LAST_IDX) begin
            state_d = ST_CSUM;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CSUM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    case (state_d)
      ST_SYNC: tx_data_d = SYNC_BYTE;
`ifdef GEIG_FRAME_LEN_EN
      ST_LEN:  tx_data_d = 8'(STACK_BYTES);
`endif
      ST_DATA: tx_data_d = byte_sel(active_d, idx_d);
      ST_CSUM: tx_data_d = csum_d;
      default: tx_data_d = 8'h00;
    endcase
    tx_valid_d = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge CLK_1MHZ or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      active_q   <= '0;
      pend_buf_q <= '0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      ovr_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pend_buf_q <= pend_buf_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      ovr_q      <= ovr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_DATA     = tx_data_q;
  assign TX_VALID    = tx_valid_q;
  assign FRAME_BUSY  = busy_q;
  assign OVERRUN_CNT = ovr_q;

endmodule
